// File: rtl/qarma_pipe_wrap.sv
// Flow-controlled timing wrapper: input capture stage, combinational tweakable
// block-cipher core, PIPE retiming stages, valid/ready on both sides.

// Combinational 128-bit tweakable block-cipher core with the qarma_top interface.
// Substitution/permutation/involutory-mix rounds; enc=0 applies the exact inverse.
// The datapath is written for N=128.
module qarma_top #(
  parameter int N = 128
) (
  input  logic         enc,
  input  logic [N-1:0] K0,
  input  logic [N-1:0] K1,
  input  logic [N-1:0] P,
  input  logic [N-1:0] T0,
  input  logic [N-1:0] T1,
  output logic [N-1:0] C
);

  localparam int          ROUNDS   = 6;
  localparam int          CELLS    = N / 4;
  localparam int          WORD     = N / 4;
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;
  localparam logic [N-1:0] RC      = N'(128'h243F6A8885A308D313198A2E03707344);

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int n);
    int s;
    s = n % N;
    return (s == 0) ? x : ((x << s) | (x >> (N - s)));
  endfunction

  function automatic logic [N-1:0] sub_cells(input logic [N-1:0] x, input logic [63:0] box);
    logic [N-1:0] y;
    y = '0;
    for (int i = 0; i < CELLS; i++) y[4*i +: 4] = box[{x[4*i +: 4], 2'b00} +: 4];
    return y;
  endfunction

  // Cell i moves to cell 5*i mod CELLS; 5 is odd, so this is a bijection.
  function automatic logic [N-1:0] perm_cells(input logic [N-1:0] x, input logic inv);
    logic [N-1:0] y;
    y = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (!inv) y[4*((5*i) % CELLS) +: 4] = x[4*i +: 4];
      else      y[4*i +: 4]               = x[4*((5*i) % CELLS) +: 4];
    end
    return y;
  endfunction

  // Each word becomes the XOR of the other three: an involution.
  function automatic logic [N-1:0] mix_words(input logic [N-1:0] x);
    logic [N-1:0]    y;
    logic [WORD-1:0] total;
    total = x[0 +: WORD] ^ x[WORD +: WORD] ^ x[2*WORD +: WORD] ^ x[3*WORD +: WORD];
    y = '0;
    for (int k = 0; k < 4; k++) y[k*WORD +: WORD] = total ^ x[k*WORD +: WORD];
    return y;
  endfunction

  logic [N-1:0] rk [ROUNDS];
  logic [N-1:0] state;

  // NOTE: every variable driven from always_comb gets a default first so no path infers a latch.
  always_comb begin
    state = '0;
    C     = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      rk[r] = K0 ^ T0 ^ rotl(K1 ^ T1, 8 * (r + 1)) ^ rotl(RC, 16 * r);
    end
    if (enc) begin
      state = P ^ K0;
      for (int r = 0; r < ROUNDS; r++) begin
        state = mix_words(perm_cells(sub_cells(state ^ rk[r], SBOX), 1'b0));
      end
      C = state ^ K1;
    end else begin
      state = P ^ K1;
      for (int r = ROUNDS - 1; r >= 0; r--) begin
        state = sub_cells(perm_cells(mix_words(state), 1'b1), SBOX_INV) ^ rk[r];
      end
      C = state ^ K0;
    end
  end

endmodule

module qarma_pipe_wrap #(
  parameter int N    = 128,
  parameter int PIPE = 2,
  parameter int TAGW = 4,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            enc,
  input  logic [N-1:0]    K0,
  input  logic [N-1:0]    K1,
  input  logic [N-1:0]    P,
  input  logic [N-1:0]    T0,
  input  logic [N-1:0]    T1,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    C,
  output logic [TAGW-1:0] out_tag,
  output logic            busy,
  output logic [CNTW-1:0] done_cnt
);

  logic            stall;
  logic            enc_q;
  logic [N-1:0]    k0_q, k1_q, p_q, t0_q, t1_q;
  logic [TAGW-1:0] tag0_q;
  logic            v0_q;
  logic [N-1:0]    core_c;

  logic [PIPE-1:0][N-1:0]    c_q,   c_d;
  logic [PIPE-1:0][TAGW-1:0] tag_q, tag_d;
  logic [PIPE-1:0]           v_q,   v_d;
  logic [CNTW-1:0]           done_cnt_q, done_cnt_d;

  // One global enable: a result waiting on the output freezes every stage.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[PIPE-1];
  assign C         = c_q[PIPE-1];
  assign out_tag   = tag_q[PIPE-1];
  assign busy      = v0_q | (|v_q);
  assign done_cnt  = done_cnt_q;

  // NOTE: data registers are reset too, so C and out_tag read 0 until the first result.
  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q  <= 1'b0;
      k0_q   <= '0;
      k1_q   <= '0;
      p_q    <= '0;
      t0_q   <= '0;
      t1_q   <= '0;
      tag0_q <= '0;
      v0_q   <= 1'b0;
    end else if (!stall) begin
      enc_q  <= enc;
      k0_q   <= K0;
      k1_q   <= K1;
      p_q    <= P;
      t0_q   <= T0;
      t1_q   <= T1;
      tag0_q <= in_tag;
      v0_q   <= in_valid;
    end
  end

  qarma_top #(.N(N)) u_core (
    .enc (enc_q),
    .K0  (k0_q),
    .K1  (k1_q),
    .P   (p_q),
    .T0  (t0_q),
    .T1  (t1_q),
    .C   (core_c)
  );

  // Bubbles travel with the data; nothing is collapsed.
  always_comb begin
    c_d   = c_q;
    tag_d = tag_q;
    v_d   = v_q;
    if (!stall) begin
      c_d[0]   = core_c;
      tag_d[0] = tag0_q;
      v_d[0]   = v0_q;
      for (int i = 1; i < PIPE; i++) begin
        c_d[i]   = c_q[i-1];
        tag_d[i] = tag_q[i-1];
        v_d[i]   = v_q[i-1];
      end
    end
  end

  assign done_cnt_d = done_cnt_q + CNTW'(out_valid & out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q        <= '0;
      tag_q      <= '0;
      v_q        <= '0;
      done_cnt_q <= '0;
    end else begin
      c_q        <= c_d;
      tag_q      <= tag_d;
      v_q        <= v_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_qarma_pipe_wrap.sv
// Self-checking bench for qarma_pipe_wrap: directed vectors, multi-cycle
// corner sequences and randomized traffic against a scoreboarded cipher model.
module tb_qarma_pipe_wrap;

  localparam int N    = 128;
  localparam int PIPE = 2;
  localparam int TAGW = 4;
  localparam int CNTW = 32;
  localparam logic [127:0] RC_REF = 128'h243F6A8885A308D313198A2E03707344;
  localparam logic [127:0] P_RT   = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, enc, out_valid, out_ready, busy;
  logic [N-1:0]    k0, k1, p, t0, t1, c;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [CNTW-1:0] done_cnt;

  qarma_pipe_wrap #(.N(N), .PIPE(PIPE), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enc       (enc),
    .K0        (k0),
    .K1        (k1),
    .P         (p),
    .T0        (t0),
    .T1        (t1),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (c),
    .out_tag   (out_tag),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]    c;
    logic [TAGW-1:0] tag;
    int              acc_cyc;
  } exp_t;

  typedef struct {
    bit              enc;
    logic [127:0]    k0, k1, p, t0, t1;
    logic [TAGW-1:0] tag;
    logic [127:0]    exp_c;
  } vec_t;

  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              n_drained;
  int              first_drain_cyc, last_drain_cyc, last_lat;
  bit              acc_last;
  logic [CNTW-1:0] model_done;
  logic [127:0]    last_c;
  logic [TAGW-1:0] last_tag;
  exp_t            sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rotl_ref(input logic [127:0] x, input int n);
    logic [255:0] d;
    d = {x, x};
    return d[255 - (n % 128) -: 128];
  endfunction

  // Cipher model on arrays of 32 nibbles / four 8-nibble words.
  function automatic logic [127:0] ref_cipher(input bit e, input logic [127:0] a0, a1, x, w0, w1);
    int sbx[16];
    int sbi[16];
    int s[32];
    int u[32];
    int acc, r;
    logic [127:0] rk[6];
    logic [127:0] v;
    sbx = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    for (int i = 0; i < 16; i++) sbi[sbx[i]] = i;
    for (int j = 0; j < 6; j++) rk[j] = a0 ^ w0 ^ rotl_ref(a1 ^ w1, 8 * (j + 1)) ^ rotl_ref(RC_REF, 16 * j);
    v = e ? (x ^ a0) : (x ^ a1);
    for (int step = 0; step < 6; step++) begin
      r = e ? step : 5 - step;
      if (e) begin
        v = v ^ rk[r];
        for (int i = 0; i < 32; i++) s[i] = sbx[v[4*i +: 4]];
        for (int i = 0; i < 32; i++) u[(5 * i) % 32] = s[i];
        for (int j = 0; j < 8; j++) begin
          acc = u[j] ^ u[8 + j] ^ u[16 + j] ^ u[24 + j];
          for (int k = 0; k < 4; k++) s[8 * k + j] = acc ^ u[8 * k + j];
        end
        for (int i = 0; i < 32; i++) v[4*i +: 4] = 4'(s[i]);
      end else begin
        for (int i = 0; i < 32; i++) s[i] = int'(v[4*i +: 4]);
        for (int j = 0; j < 8; j++) begin
          acc = s[j] ^ s[8 + j] ^ s[16 + j] ^ s[24 + j];
          for (int k = 0; k < 4; k++) u[8 * k + j] = acc ^ s[8 * k + j];
        end
        for (int i = 0; i < 32; i++) s[i] = sbi[u[(5 * i) % 32]];
        for (int i = 0; i < 32; i++) v[4*i +: 4] = 4'(s[i]);
        v = v ^ rk[r];
      end
    end
    return e ? (v ^ a1) : (v ^ a0);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: called just after a falling edge with inputs already driven.
  task automatic do_cycle();
    exp_t e;
    #1;
    check("busy", 128'(busy), 128'(sb.size() != 0));
    check("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
    check("done_cnt", 128'(done_cnt), 128'(model_done));
    check("occupancy", 128'(sb.size() <= PIPE + 1), 128'(1));
    acc_last = 1'b0;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 128'(out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        check("result_C", c, e.c);
        check("result_tag", 128'(out_tag), 128'(e.tag));
        last_lat = cyc - e.acc_cyc;
        check("latency_min", 128'(last_lat >= PIPE + 1), 128'(1));
        if (n_drained == 0) first_drain_cyc = cyc;
        last_drain_cyc = cyc;
        last_c   = c;
        last_tag = out_tag;
        n_drained++;
        model_done++;
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back('{ref_cipher(enc, k0, k1, p, t0, t1), in_tag, cyc});
      acc_last = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int b;
    b = 0;
    while ((in_valid || sb.size() != 0) && b < bound) begin
      do_cycle();
      if (acc_last) in_valid = 1'b0;
      b++;
    end
    check("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    sb.delete();
    model_done = '0;
    n_drained  = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic single_op(input bit e, input logic [127:0] a0, a1, x, w0, w1, input logic [TAGW-1:0] tg);
    enc = e; k0 = a0; k1 = a1; p = x; t0 = w0; t1 = w1; in_tag = tg;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    do_cycle();
    in_valid = 1'b0;
    drain(20);
  endtask

  vec_t            vecs[5];
  int              n_ov;
  logic [127:0]    ct, hold_c;
  logic [TAGW-1:0] hold_tag;

  initial begin
    rst = 1'b1; in_valid = 1'b0; enc = 1'b0; out_ready = 1'b1;
    k0 = '0; k1 = '0; p = '0; t0 = '0; t1 = '0; in_tag = '0;
    model_done = '0; n_drained = 0; acc_last = 1'b0;

    vecs[0] = '{1'b1, '0, '0, '0, '0, '0, 4'd5, '0};
    vecs[1] = '{1'b1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 4'd9, '0};
    vecs[2] = '{1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 4'd0, '0};
    vecs[3] = '{1'b1, '1, '1, '1, '1, '1, 4'd15, '0};
    vecs[4] = '{1'b0, 128'h1, 128'h2, P_RT, 128'h3, 128'h4, 4'd10, '0};
    foreach (vecs[i]) vecs[i].exp_c = ref_cipher(vecs[i].enc, vecs[i].k0, vecs[i].k1, vecs[i].p, vecs[i].t0, vecs[i].t1);

    // Reset held with a request pending.
    @(negedge clk);
    in_valid = 1'b1; p = rnd128(); in_tag = 4'd7;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_C", c, 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    check("rst_done_cnt", 128'(done_cnt), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    rst = 1'b0;
    n_ov = 0;
    repeat (10) begin
      if (out_valid) n_ov++;
      do_cycle();
    end
    check("idle_no_result", 128'(n_ov), 128'(0));

    // Vector table: one isolated operation each.
    reset_dut(2);
    foreach (vecs[i]) begin
      single_op(vecs[i].enc, vecs[i].k0, vecs[i].k1, vecs[i].p, vecs[i].t0, vecs[i].t1, vecs[i].tag);
      check("vec_C", last_c, vecs[i].exp_c);
      check("vec_tag", 128'(last_tag), 128'(vecs[i].tag));
      check("vec_latency", 128'(last_lat), 128'(PIPE + 1));
      check("vec_done_cnt", 128'(done_cnt), 128'(i + 1));
    end

    // Round trip: encrypt, then decrypt the DUT's own ciphertext.
    single_op(1'b1, 128'hA5A5, 128'h5A5A0000, P_RT, 128'h1111, 128'h2222, 4'd1);
    ct = last_c;
    single_op(1'b0, 128'hA5A5, 128'h5A5A0000, ct, 128'h1111, 128'h2222, 4'd2);
    check("round_trip", last_c, P_RT);

    // Streaming 20 back-to-back requests.
    reset_dut(2);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enc = 1'(i); k0 = rnd128(); k1 = rnd128(); p = rnd128(); t0 = rnd128(); t1 = rnd128();
      in_tag = 4'(i % 16);
      in_valid = 1'b1;
      do_cycle();
    end
    in_valid = 1'b0;
    drain(30);
    check("stream_count", 128'(n_drained), 128'(20));
    check("stream_consecutive", 128'(last_drain_cyc - first_drain_cyc), 128'(19));
    check("stream_done_cnt", 128'(done_cnt), 128'(20));

    // Backpressure with a full pipe.
    reset_dut(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enc = 1'b1; k0 = rnd128(); k1 = rnd128(); p = rnd128(); t0 = rnd128(); t1 = rnd128();
      in_tag = 4'(i + 1);
      in_valid = 1'b1;
      do_cycle();
    end
    k0 = rnd128(); p = rnd128(); in_tag = 4'd4;
    for (int j = 0; j < 5; j++) begin
      #1;
      if (j == 0) begin
        hold_c = c;
        hold_tag = out_tag;
      end
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_C_stable", c, hold_c);
      check("bp_tag_stable", 128'(out_tag), 128'(hold_tag));
      check("bp_in_flight", 128'(sb.size()), 128'(3));
      do_cycle();
    end
    out_ready = 1'b1;
    drain(20);
    check("bp_drained", 128'(n_drained), 128'(4));
    check("bp_done_cnt", 128'(done_cnt), 128'(4));

    // Reset while three operations are in flight.
    reset_dut(2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enc = 1'b0; k0 = rnd128(); k1 = rnd128(); p = rnd128(); t0 = rnd128(); t1 = rnd128();
      in_tag = 4'(8 + i);
      in_valid = 1'b1;
      do_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("mid_pre_done_cnt", 128'(done_cnt), 128'(1));
    check("mid_pre_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_busy", 128'(busy), 128'(0));
    check("mid_out_valid", 128'(out_valid), 128'(0));
    check("mid_done_cnt", 128'(done_cnt), 128'(0));
    sb.delete();
    model_done = '0;
    n_drained = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      k0 = rnd128(); p = rnd128(); in_tag = 4'(i + 1);
      in_valid = 1'b1;
      do_cycle();
    end
    in_valid = 1'b0;
    drain(20);
    check("mid_post_count", 128'(n_drained), 128'(2));
    check("mid_post_done_cnt", 128'(done_cnt), 128'(2));

    // Randomized traffic with random backpressure.
    reset_dut(2);
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom % 4) != 0;
        enc = 1'($urandom);
        k0 = rnd128(); k1 = rnd128(); p = rnd128(); t0 = rnd128(); t1 = rnd128();
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      do_cycle();
    end
    out_ready = 1'b1;
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
